// File: rtl/dist_ram_fifo.sv
// Parametrised first-word-fall-through FIFO on distributed (shadow) RAM.
// Flags and occupancy derive only from registered pointers and count; sticky overflow/underflow flags are kept until rst.
module dist_ram_fifo #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 3,
  parameter int AFULL_LVL = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  din,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  dout,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AFULL_THR = AFULL_LVL[ADDR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] count_q;
  logic            overflow_q;
  logic            underflow_q;

  logic            wr_acc;
  logic            rd_acc;

  // Flags come from the registered pointers only; the MSB breaks the full/empty tie.
  always_comb begin
    empty       = (wr_ptr == rd_ptr);
    full        = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                  (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    almost_full = (count_q >= AFULL_THR);
    wr_acc      = wr_en & ~full;
    rd_acc      = rd_en & ~empty;
  end

  // Storage: synchronous write, asynchronous read, contents never reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr[ADDR_W-1:0]] <= din;
    end
  end

  assign dout = mem[rd_ptr[ADDR_W-1:0]];

  // Control: pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_en && full) begin
        overflow_q <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_dist_ram_fifo.sv
// Bench for dist_ram_fifo: directed scenarios followed by random traffic, all checked
// against a queue-based model of FIFO behaviour.
module tb_dist_ram_fifo;

  localparam int WIDTH     = 32;
  localparam int ADDR_W    = 3;
  localparam int AFULL_LVL = 6;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [WIDTH-1:0]  din;
  logic              rd_en;
  logic [WIDTH-1:0]  dout;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  dist_ram_fifo #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AFULL_LVL(AFULL_LVL)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] q [$];
  bit   m_ovf;
  bit   m_unf;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, ".afull"}, 32'(almost_full), 32'(q.size() >= AFULL_LVL));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    if (q.size() != 0) chk({tag, ".dout"}, dout, q[0]);
  endtask

  // One clock: drive requests, advance the model from the pre-edge state, check after the edge.
  task automatic step(input string tag, input bit w, input bit r, input logic [WIDTH-1:0] d);
    bit full_m;
    bit empty_m;
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    full_m  = (q.size() == DEPTH);
    empty_m = (q.size() == 0);
    if (w && full_m)  m_ovf = 1'b1;
    if (r && empty_m) m_unf = 1'b1;
    if (r && !empty_m) void'(q.pop_front());
    if (w && !full_m)  q.push_back(d);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input string tag, input bit w, input bit r);
    rst   = 1'b1;
    wr_en = w;
    rd_en = r;
    din   = 32'hBAD0_0001;
    @(posedge clk);
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_state(tag);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    m_ovf = 1'b0; m_unf = 1'b0;

    // Reset, then idle.
    do_reset("reset", 1'b0, 1'b0);
    step("idle", 1'b0, 1'b0, '0);

    // Fill with 0x11..0x88, then drain in order.
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b0, 32'(i * 8'h11));
    chk("fill.full_final", 32'(full), 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain.head", dout, 32'(i * 8'h11));
      step("drain", 1'b0, 1'b1, '0);
    end
    chk("drain.empty_final", 32'(empty), 32'd1);

    // Overflow: writes while full are dropped.
    for (int i = 0; i < DEPTH; i++) step("ovf.fill", 1'b1, 1'b0, 32'(100 + i));
    step("ovf.write", 1'b1, 1'b0, 32'hDEAD);
    chk("ovf.flag", 32'(overflow), 32'd1);
    // Full with both requests: read wins, write rejected.
    step("ovf.both", 1'b1, 1'b1, 32'hDEAD);
    chk("ovf.both_count", 32'(count), 32'(DEPTH - 1));
    for (int i = 0; i < DEPTH - 1; i++) begin
      chk("ovf.no_dead", 32'(dout == 32'hDEAD), 32'd0);
      step("ovf.drain", 1'b0, 1'b1, '0);
    end

    // Sustained simultaneous traffic at count=3 across pointer wrap.
    do_reset("wrap.rst", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("wrap.pre", 1'b1, 1'b0, 32'(200 + i));
    for (int i = 0; i < 20; i++) step("wrap.both", 1'b1, 1'b1, 32'(300 + i));
    chk("wrap.count", 32'(count), 32'd3);

    // Empty with both requests: write accepted, underflow set.
    for (int i = 0; i < 3; i++) step("unf.drain", 1'b0, 1'b1, '0);
    step("unf.both", 1'b1, 1'b1, 32'h5A);
    chk("unf.flag", 32'(underflow), 32'd1);
    chk("unf.dout", dout, 32'h5A);

    // Reset mid-operation with a write pending.
    for (int i = 0; i < 4; i++) step("rst.fill", 1'b1, 1'b0, 32'(400 + i));
    chk("rst.count5", 32'(count), 32'd5);
    do_reset("rst.mid", 1'b1, 1'b0);
    step("rst.after", 1'b0, 1'b0, '0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd.rst", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        step("rnd", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dist_ram_fifo.md
# dist_ram_fifo

Parametrised synchronous FIFO built on the Gowin shadow (distributed) SRAM. It is the generalised successor to the fixed 32x8 shadow-RAM wrapper: data width and depth are set by parameters, and it adds pointer and occupancy tracking, full/empty flags, a programmable almost-full threshold and sticky error flags. It sits between LED-pattern producers and the LED driver as a small elastic buffer in the single fabric clock domain.

## Interface
- WIDTH, 32, data word width in bits (1..64).
- ADDR_W, 3, log2 of depth; depth = 2**ADDR_W (2..4, i.e. 4..16 entries, fits RAM16S4 tiles).
- AFULL_LVL, 6, almost_full asserts when count >= AFULL_LVL (1..2**ADDR_W).

- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- rd_en  in  1  read (pop) request.
- dout  out  WIDTH  head-of-queue data, first-word-fall-through.
- empty  out  1  no entries stored.
- full  out  1  2**ADDR_W entries stored.
- almost_full  out  1  count >= AFULL_LVL.
- count  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Storage: 2**ADDR_W x WIDTH array, synchronous write on clk, asynchronous read; maps to RAM16S4 primitives, contents not reset.
- Pointers wr_ptr, rd_ptr are ADDR_W+1 bits; address uses low ADDR_W bits; MSB distinguishes full from empty. Pointers wrap modulo 2**(ADDR_W+1) with no special handling.
- wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty. Acceptance uses flags registered from the previous cycle; no write pass-through when full, no read pass-through when empty.
- wr_acc: mem[wr_ptr] <= din, wr_ptr increments. rd_acc: rd_ptr increments.
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- empty = (wr_ptr == rd_ptr); full = (address bits equal, MSBs differ); almost_full from count. All flags derived from registers, no dependence on same-cycle inputs.
- dout = mem[rd_ptr[ADDR_W-1:0]] combinationally; valid whenever empty = 0; value when empty is don't-care.
- overflow set on wr_en & full; underflow set on rd_en & empty; both held until rst.
- Rejected requests change no state other than the sticky flags.
- Reset: wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, almost_full = 0 (AFULL_LVL >= 1), overflow = underflow = 0. Reset mid-operation discards all entries in one cycle; rst has priority over wr_en/rd_en on the same edge.

## Timing
- Write latency: write accepted at edge N -> empty deasserts, count updates and dout shows the word after edge N (usable in cycle N+1).
- Read: dout is valid in the cycle rd_en is asserted; pop takes effect at the edge; next word on dout after that edge.
- Simultaneous wr_acc and rd_acc with count between 1 and depth-1: both occur, count unchanged, flags unchanged.
- Full with wr_en and rd_en both high: read accepted, write rejected, overflow set, count = depth-1 afterwards.
- Empty with wr_en and rd_en both high: write accepted, read rejected, underflow set, count = 1 afterwards.
- Throughput: one write and one read per cycle sustained.

## Test plan
- Reset then idle -> empty=1, full=0, count=0, overflow=underflow=0.
- ADDR_W=3: write 0x11..0x88 on 8 consecutive cycles -> full=1 after 8th edge, almost_full=1 from 6th edge, count=8; read 8 -> dout sequence 0x11..0x88, empty=1.
- Fill to 8, assert wr_en with din=0xDEAD -> overflow=1, count stays 8, 0xDEAD never appears on dout.
- 20 cycles of simultaneous write/read at count=3 -> count stays 3, in-order data across pointer wrap (wr_ptr 15->0).
- Empty, wr_en=rd_en=1 with din=0x5A -> underflow=1, count=1, dout=0x5A next cycle.
- Count=5, assert rst with wr_en=1 -> count=0, empty=1, sticky flags cleared, write dropped.
